// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: row strobing, press/release debounce, one-shot code strobe.
// Optional auto-repeat while a key is held is compiled in with `define KEY_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] code,
  output logic       rd_enable,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("keypad_scan_ctrl: invalid parameter set");
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_cnt;
`endif

  typedef enum logic [2:0] {SCAN, DEBOUNCE, CAPTURE, HELD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    sync1, sync2;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb_cnt;
  logic [1:0]    row_idx, col_idx;
  logic          col_hit;

  assign col_hit = sync2[col_idx];

  function automatic logic [3:0] rot(input logic [3:0] r);
    return {r[2:0], r[3]};
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (c[0])      return 2'd0;
    else if (c[1]) return 2'd1;
    else if (c[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [1:0] enc_row(input logic [3:0] r);
    if (r[1])      return 2'd1;
    else if (r[2]) return 2'd2;
    else if (r[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  // Counters stop at their terminal value and are reloaded, so none can wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SCAN;
      sync1     <= '0;
      sync2     <= '0;
      dwell     <= '0;
      deb_cnt   <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      row_out   <= 4'b0001;
      code      <= '0;
      rd_enable <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      sync1     <= col_in;
      sync2     <= sync1;
      rd_enable <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (|sync2) begin
              row_idx <= enc_row(row_out);
              col_idx <= low_col(sync2);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_out <= rot(row_out);
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (!col_hit) begin
            row_out <= rot(row_out);
            deb_cnt <= '0;
            dwell   <= '0;
            state   <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            state   <= CAPTURE;
          end else begin
            deb_cnt <= deb_cnt + BW'(1);
          end
        end
        CAPTURE: begin
          code      <= {row_idx, col_idx};
          rd_enable <= 1'b1;
          key_down  <= 1'b1;
          state     <= HELD;
`ifdef KEY_REPEAT_EN
          rpt_cnt   <= '0;
`endif
        end
        HELD: begin
          if (!col_hit) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
`ifdef KEY_REPEAT_EN
          else if (rpt_cnt == RPT_LAST) begin
            rd_enable <= 1'b1;
            rpt_cnt   <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
`endif
        end
        RELEASE: begin
          if (col_hit) begin
            deb_cnt <= '0;
            state   <= HELD;
`ifdef KEY_REPEAT_EN
            rpt_cnt <= '0;
`endif
          end else if (deb_cnt == DEB_LAST) begin
            key_down <= 1'b0;
            row_out  <= rot(row_out);
            dwell    <= '0;
            deb_cnt  <= '0;
            state    <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + BW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
